// File: rtl/bcd_group_counter.sv
// -----------------------------------------------------------------------------
// bcd_group_counter
//
// Counts single-cycle item events in groups of GROUP_SIZE and accumulates the
// number of completed groups as a DIGITS-wide BCD total for 7-segment display.
// Everything runs in the clk domain. There are no derived clocks.
//
// Parameters
//   GROUP_SIZE  items per group (2..2**PW)
//   PW          width of the partial-group count
//   DIGITS      number of BCD digits in the total (1..8)
//   WRAP        1: total wraps all-9s -> 0; 0: total saturates at all-9s
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   item_in     in   one item counted on each rising edge where it is 1
//   clear       in   synchronous clear of counts and flags (beats item_in)
//   partial     out  items in the current incomplete group
//   bcd_total   out  completed groups in BCD, digit i at [4i+3:4i]
//   group_done  out  one-cycle pulse on the cycle after a group completes
//   overflow    out  sticky flag: the total stepped past all-9s
// -----------------------------------------------------------------------------
module bcd_group_counter #(
  parameter int GROUP_SIZE = 12,
  parameter int PW         = 4,
  parameter int DIGITS     = 2,
  parameter bit WRAP       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  item_in,
  input  logic                  clear,
  output logic [PW-1:0]         partial,
  output logic [4*DIGITS-1:0]   bcd_total,
  output logic                  group_done,
  output logic                  overflow
);

  localparam logic [PW-1:0] LAST_ITEM = PW'(GROUP_SIZE - 1);

  logic [PW-1:0]       partial_q,  partial_d;
  logic [4*DIGITS-1:0] total_q,    total_d;
  logic                done_q,     done_d;
  logic                overflow_q, overflow_d;

  logic [4*DIGITS-1:0] total_inc;
  logic                total_all_nines;

  // Decimal increment of the total. The carry ripples through every digit
  // in the same cycle; a carry out of the top digit means the total was all 9s.
  always_comb begin
    logic carry;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    carry     = 1'b1;
    total_inc = total_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (total_q[4*i +: 4] == 4'd9) begin
          total_inc[4*i +: 4] = 4'd0;
        end else begin
          total_inc[4*i +: 4] = total_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    total_all_nines = carry;
  end

  // Next state: clear > item_in > hold. group_done defaults low so it can only
  // ever be a single-cycle pulse.
  always_comb begin
    partial_d  = partial_q;
    total_d    = total_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    if (clear) begin
      partial_d  = '0;
      total_d    = '0;
      overflow_d = 1'b0;
    end else if (item_in) begin
      if (partial_q == LAST_ITEM) begin
        partial_d = '0;
        done_d    = 1'b1;
        if (total_all_nines) begin
          overflow_d = 1'b1;
          // Wrap uses the carried-out increment (all zeros); saturate holds.
          total_d    = WRAP ? total_inc : total_q;
        end else begin
          total_d = total_inc;
        end
      end else begin
        partial_d = partial_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      partial_q  <= '0;
      total_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      partial_q  <= partial_d;
      total_q    <= total_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign partial    = partial_q;
  assign bcd_total  = total_q;
  assign group_done = done_q;
  assign overflow   = overflow_q;

endmodule
